// File: rtl/alu_op_sequencer.sv
// Multicycle controller that steps the shared ALU through one ALU-class instruction:
// accept, decode into SrcA/SrcB/AluOp, capture the result, then pulse a single writeback.
module alu_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int OPC_MSB = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] instr,
    output logic             instr_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             clr_ovf,
    output logic             SrcA,
    output logic [1:0]       SrcB,
    output logic [2:0]       AluOp,
    output logic             mary_we,
    output logic             sp_we,
    output logic [WIDTH-1:0] wb_data,
    output logic             done,
    output logic             illegal,
    output logic             overflow_flag,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

    localparam logic [3:0] OPC_SPADD   = 4'hE;
    localparam logic [3:0] OPC_ILLEGAL = 4'hF;

    state_t     state;
    state_t     next_state;
    logic [3:0] opcode;
    logic       dec_a;
    logic [1:0] dec_b;
    logic [2:0] dec_op;
    logic       ovf_op;
    logic       unused_instr_bits;

    // Only the opcode field is consumed; the rest of the word is for other units.
    assign unused_instr_bits = ^instr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (instr_valid) next_state = DECODE;
            DECODE:  next_state = (opcode == OPC_ILLEGAL) ? ERR : EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        done        = (state == WB);
        mary_we     = (state == WB) && (opcode != OPC_SPADD);
        sp_we       = (state == WB) && (opcode == OPC_SPADD);
        illegal     = (state == ERR);
    end

    always_comb begin
        dec_a  = 1'b0;
        dec_b  = 2'b00;
        dec_op = 3'b000;
        case (opcode)
            4'h0: begin dec_b = 2'b01; dec_op = 3'b000; end
            4'h1: begin dec_b = 2'b01; dec_op = 3'b001; end
            4'h2: begin dec_b = 2'b00; dec_op = 3'b000; end
            4'h3: begin dec_b = 2'b00; dec_op = 3'b001; end
            4'h4: begin dec_b = 2'b10; dec_op = 3'b010; end
            4'h5: begin dec_b = 2'b10; dec_op = 3'b011; end
            4'h6: begin dec_b = 2'b00; dec_op = 3'b010; end
            4'h7: begin dec_b = 2'b00; dec_op = 3'b011; end
            4'h8: begin dec_b = 2'b10; dec_op = 3'b100; end
            4'h9: begin dec_b = 2'b00; dec_op = 3'b100; end
            4'hA: begin dec_b = 2'b10; dec_op = 3'b101; end
            4'hB: begin dec_b = 2'b00; dec_op = 3'b101; end
            4'hC: begin dec_b = 2'b10; dec_op = 3'b110; end
            4'hD: begin dec_b = 2'b00; dec_op = 3'b110; end
            4'hE: begin dec_a = 1'b1; dec_b = 2'b11; dec_op = 3'b010; end
            default: ;
        endcase
    end

    // Only the add/subtract family can report a meaningful signed overflow.
    assign ovf_op = (opcode inside {4'h4, 4'h5, 4'h6, 4'h7, OPC_SPADD});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opcode        <= 4'h0;
            SrcA          <= 1'b0;
            SrcB          <= 2'b00;
            AluOp         <= 3'b000;
            wb_data       <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (state == IDLE && instr_valid) begin
                opcode <= instr[OPC_MSB -: 4];
            end
            if (state == DECODE && opcode != OPC_ILLEGAL) begin
                SrcA  <= dec_a;
                SrcB  <= dec_b;
                AluOp <= dec_op;
            end
            if (state == EXEC) begin
                wb_data <= alu_out;
            end
            if (state == EXEC && alu_overflow && ovf_op) begin
                overflow_flag <= 1'b1;
            end else if (clr_ovf) begin
                overflow_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: a bench-side ALU drives alu_out from the selects, while a transaction-level
// model schedules the expected outputs from each accepted opcode's meaning.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        clr_ovf = 1'b0;
    logic [15:0] alu_out;
    logic        alu_overflow;
    logic        instr_ready, SrcA, mary_we, sp_we, done, illegal, overflow_flag, busy;
    logic [1:0]  SrcB;
    logic [2:0]  AluOp;
    logic [15:0] wb_data;

    logic [15:0] mary = 16'd57, shelley = 16'd75, zext = 16'd80, sext = 16'd34;
    logic [15:0] sp = 16'd62, sext_ls = 16'd136;
    logic        ovf_force = 1'b0;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(.WIDTH(16), .OPC_MSB(15)) dut (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_out(alu_out), .alu_overflow(alu_overflow),
        .clr_ovf(clr_ovf), .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp), .mary_we(mary_we),
        .sp_we(sp_we), .wb_data(wb_data), .done(done), .illegal(illegal),
        .overflow_flag(overflow_flag), .busy(busy)
    );

    always #5 clock = ~clock;

    // Bench ALU: operates on whatever the sequencer currently selects.
    logic [15:0] op_a, op_b;
    always_comb begin
        op_a = SrcA ? sp : mary;
        op_b = 16'h0;
        case (SrcB)
            2'b00: op_b = shelley;
            2'b01: op_b = zext;
            2'b10: op_b = sext;
            2'b11: op_b = sext_ls;
            default: op_b = 16'h0;
        endcase
        alu_out = 16'h0;
        case (AluOp)
            3'b000: alu_out = op_a & op_b;
            3'b001: alu_out = op_a | op_b;
            3'b010: alu_out = op_a + op_b;
            3'b011: alu_out = op_a - op_b;
            3'b100: alu_out = {15'h0, $signed(op_a) < $signed(op_b)};
            3'b101: alu_out = {15'h0, $signed(op_a) > $signed(op_b)};
            3'b110: alu_out = {15'h0, op_a == op_b};
            default: alu_out = 16'h0;
        endcase
        alu_overflow = ovf_force;
    end

    // Meaning of each opcode in terms of named registers.
    function automatic logic [15:0] model_result(input logic [3:0] op);
        case (op)
            4'h0: return mary & zext;
            4'h1: return mary | zext;
            4'h2: return mary & shelley;
            4'h3: return mary | shelley;
            4'h4: return mary + sext;
            4'h5: return mary - sext;
            4'h6: return mary + shelley;
            4'h7: return mary - shelley;
            4'h8: return {15'h0, $signed(mary) < $signed(sext)};
            4'h9: return {15'h0, $signed(mary) < $signed(shelley)};
            4'hA: return {15'h0, $signed(mary) > $signed(sext)};
            4'hB: return {15'h0, $signed(mary) > $signed(shelley)};
            4'hC: return {15'h0, mary == sext};
            4'hD: return {15'h0, mary == shelley};
            4'hE: return sp + sext_ls;
            default: return 16'h0;
        endcase
    endfunction

    // Expected {SrcA, SrcB, AluOp} for each legal opcode.
    function automatic logic [5:0] model_selects(input logic [3:0] op);
        case (op)
            4'h0: return 6'b0_01_000;
            4'h1: return 6'b0_01_001;
            4'h2: return 6'b0_00_000;
            4'h3: return 6'b0_00_001;
            4'h4: return 6'b0_10_010;
            4'h5: return 6'b0_10_011;
            4'h6: return 6'b0_00_010;
            4'h7: return 6'b0_00_011;
            4'h8: return 6'b0_10_100;
            4'h9: return 6'b0_00_100;
            4'hA: return 6'b0_10_101;
            4'hB: return 6'b0_00_101;
            4'hC: return 6'b0_10_110;
            4'hD: return 6'b0_00_110;
            default: return 6'b1_11_010;
        endcase
    endfunction

    // Transaction model: a handshake at edge c schedules selects at c+1, result and pulse at c+2.
    int          cyc = 0;
    int          busy_until = 0;
    int          hs_cyc = -100;
    logic        m_pending = 1'b0;
    logic [3:0]  m_op = 4'h0;
    logic [5:0]  m_sel = 6'h0;
    logic [15:0] m_wb = 16'h0;
    logic        m_ovf = 1'b0;
    logic        m_ready_now, m_set_ovf;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_until = 0;
            hs_cyc     = -100;
            m_pending  = 1'b0;
            m_sel      = 6'h0;
            m_wb       = 16'h0;
            m_ovf      = 1'b0;
        end else begin
            m_ready_now = (cyc >= busy_until);
            cyc         = cyc + 1;
            m_set_ovf   = 1'b0;
            if (m_pending && m_op != 4'hF && cyc == hs_cyc + 1) m_sel = model_selects(m_op);
            if (m_pending && m_op != 4'hF && cyc == hs_cyc + 2) begin
                m_wb      = model_result(m_op);
                m_set_ovf = ovf_force && (m_op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
            end
            if (m_set_ovf) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (m_ready_now && instr_valid) begin
                hs_cyc     = cyc;
                m_op       = instr[15:12];
                m_pending  = 1'b1;
                busy_until = cyc + ((instr[15:12] == 4'hF) ? 2 : 3);
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    logic e_ready, e_pulse;
    always @(negedge clock) begin
        if (reset_n) begin
            e_ready = (cyc >= busy_until);
            e_pulse = m_pending && m_op != 4'hF && cyc == hs_cyc + 2;
            check_output("instr_ready", {15'h0, instr_ready}, {15'h0, e_ready});
            check_output("busy", {15'h0, busy}, {15'h0, !e_ready});
            check_output("mary_we", {15'h0, mary_we}, {15'h0, e_pulse && m_op != 4'hE});
            check_output("sp_we", {15'h0, sp_we}, {15'h0, e_pulse && m_op == 4'hE});
            check_output("done", {15'h0, done}, {15'h0, e_pulse});
            check_output("illegal", {15'h0, illegal},
                         {15'h0, m_pending && m_op == 4'hF && cyc == hs_cyc + 1});
            check_output("selects", {10'h0, SrcA, SrcB, AluOp}, {10'h0, m_sel});
            check_output("wb_data", wb_data, m_wb);
            check_output("overflow_flag", {15'h0, overflow_flag}, {15'h0, m_ovf});
        end
    end

    // Offers an instruction until it is accepted; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [15:0] word, input logic hold, output int hs_at);
        logic got, rdy;
        got         = 1'b0;
        hs_at       = -1;
        instr       = word;
        instr_valid = 1'b1;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clock);
            rdy = instr_ready;
            @(posedge clock);
            if (rdy) got = 1'b1;
        end
        #2;
        if (!hold) instr_valid = 1'b0;
        hs_at = cyc;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got no accept required accept of %0h", word);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    int t0, t1;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        check_output("rst_ready", {15'h0, instr_ready}, 16'h1);
        check_output("rst_sel", {10'h0, SrcA, SrcB, AluOp}, 16'h0);
        check_output("rst_wb", wb_data, 16'h0);
        #2 reset_n = 1'b1;
        step(1);

        // aadd: 57 + 34
        apply_stimulus(16'h4000, 1'b0, t0);
        step(1);
        check_output("t1_srcb", {14'h0, SrcB}, 16'h2);
        check_output("t1_aluop", {13'h0, AluOp}, 16'h2);
        step(1);
        check_output("t1_wb", wb_data, 16'd91);
        check_output("t1_mary_we", {15'h0, mary_we}, 16'h1);
        check_output("t1_done", {15'h0, done}, 16'h1);
        check_output("t1_sp_we", {15'h0, sp_we}, 16'h0);
        step(1);
        check_output("t1_mary_we_off", {15'h0, mary_we}, 16'h0);

        // asub@ then spadd
        apply_stimulus(16'h7000, 1'b0, t0);
        step(1);
        check_output("t2_sel", {10'h0, SrcA, SrcB, AluOp}, 16'b0_00_011);
        step(1);
        check_output("t2_wb", wb_data, 16'hFFEE);
        check_output("t2_mary_we", {15'h0, mary_we}, 16'h1);
        step(1);
        apply_stimulus(16'hE000, 1'b0, t0);
        step(1);
        check_output("t2_sp_sel", {13'h0, SrcA, SrcB}, 16'b1_11);
        step(1);
        check_output("t2_sp_wb", wb_data, 16'd198);
        check_output("t2_sp_we", {15'h0, sp_we}, 16'h1);
        check_output("t2_sp_mary_we", {15'h0, mary_we}, 16'h0);
        step(1);

        // illegal opcode: selects keep the spadd values
        apply_stimulus(16'hF000, 1'b0, t0);
        step(1);
        check_output("t3_illegal", {15'h0, illegal}, 16'h1);
        check_output("t3_no_we", {13'h0, mary_we, sp_we, done}, 16'h0);
        check_output("t3_sel_hold", {10'h0, SrcA, SrcB, AluOp}, 16'b1_11_010);
        step(2);
        check_output("t3_ready", {15'h0, instr_ready}, 16'h1);
        check_output("t3_illegal_off", {15'h0, illegal}, 16'h0);

        // every legal opcode with assorted low bits
        for (int op = 0; op < 14; op++) begin
            apply_stimulus({op[3:0], 12'hA5C}, 1'b0, t0);
            step(3);
        end

        // sticky overflow
        ovf_force = 1'b1;
        apply_stimulus(16'h4000, 1'b0, t0);
        step(4);
        check_output("t4_ovf_set", {15'h0, overflow_flag}, 16'h1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check_output("t4_ovf_clr", {15'h0, overflow_flag}, 16'h0);
        apply_stimulus(16'h8000, 1'b0, t0);
        step(4);
        check_output("t4_ovf_slt", {15'h0, overflow_flag}, 16'h0);
        apply_stimulus(16'h5000, 1'b0, t0);
        step(1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check_output("t4_ovf_set_wins", {15'h0, overflow_flag}, 16'h1);
        ovf_force = 1'b0;
        step(2);
        check_output("t4_ovf_sticky", {15'h0, overflow_flag}, 16'h1);

        // back-to-back with valid held high
        apply_stimulus(16'h6000, 1'b1, t0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_output("t5_ready_low", {15'h0, instr_ready}, 16'h0);
        end
        apply_stimulus(16'h1000, 1'b0, t1);
        check_output("t5_hs_gap", 16'(t1 - t0), 16'd4);
        step(2);
        check_output("t5_done2", {15'h0, done}, 16'h1);
        check_output("t5_wb2", wb_data, 16'h0079);
        step(1);

        // reset in the middle of EXEC
        apply_stimulus(16'h4000, 1'b0, t0);
        step(1);
        reset_n = 1'b0;
        #1;
        check_output("t6_ready", {15'h0, instr_ready}, 16'h1);
        check_output("t6_busy", {15'h0, busy}, 16'h0);
        check_output("t6_sel", {10'h0, SrcA, SrcB, AluOp}, 16'h0);
        check_output("t6_wb", wb_data, 16'h0);
        check_output("t6_ovf", {15'h0, overflow_flag}, 16'h0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_output("t6_no_we", {14'h0, mary_we, done}, 16'h0);
        end
        check_output("t6_ready_after", {15'h0, instr_ready}, 16'h1);
        step(1);
        apply_stimulus(16'hC000, 1'b0, t0);
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
